fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised multi-slot instruction queue between the fetch stage and decode. It accepts up to ENQ_WIDTH fetched instructions per cycle, each as pc, data and taken_branch, and compacts sparse valid masks from partial icache accesses. Instructions following a predicted-taken branch within the same packet are dropped. Decode can pop up to DEQ_WIDTH instructions per cycle, in order. It generalises the fixed two-instruction fetched-packet handoff to arbitrary widths and depths, with flush and stall handling.

## Interface
- PC_BITS, 32, instruction address width
- INSTR_BITS, 32, instruction word width
- ENQ_WIDTH, 2, instruction slots per fetch packet
- DEQ_WIDTH, 2, max instructions popped per cycle
- DEPTH, 8, entries; power of 2, DEPTH >= max(ENQ_WIDTH, DEQ_WIDTH)
- CW = $clog2(DEPTH+1), PW = $clog2(DEQ_WIDTH+1) (derived localparams)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all contents and this cycle's enqueue
- enq_valid  in  1  fetch packet present
- enq_mask  in  ENQ_WIDTH  per-slot valid; any pattern allowed
- enq_pc  in  ENQ_WIDTH*PC_BITS  slot i at [i*PC_BITS +: PC_BITS]
- enq_data  in  ENQ_WIDTH*INSTR_BITS  slot i instruction word
- enq_taken  in  ENQ_WIDTH  slot i predicted taken branch
- enq_ready  out  1  queue can accept a full packet
- deq_valid  out  DEQ_WIDTH  thermometer; bit i = head+i valid
- deq_pc  out  DEQ_WIDTH*PC_BITS  head+i pc
- deq_data  out  DEQ_WIDTH*INSTR_BITS  head+i instruction
- deq_taken  out  DEQ_WIDTH  head+i taken_branch
- deq_pop  in  PW  instructions consumed this cycle
- count  out  CW  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer, entry = {pc, data, taken} (PC_BITS+INSTR_BITS+1 bits); head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count held explicitly (distinguishes full from empty).
- enq_ready = (count <= DEPTH-ENQ_WIDTH), computed from registered count only; pops in the same cycle are not credited.
- Accept = enq_valid & enq_ready & !flush.
- Effective mask: clear every enq_mask bit above the lowest slot i with enq_mask[i] & enq_taken[i]. The taken slot itself is kept.
- Compaction: effective-valid slots are written in ascending slot order to tail, tail+1, … ; N = popcount(effective mask), 0..ENQ_WIDTH. N = 0 is legal and a no-op.
- Dequeue: deq_valid[i] = (count > i). Deq payloads are read combinationally from storage at head+i (mod DEPTH). Payload is don't-care where deq_valid[i]=0.
- Pop: P = min(deq_pop, popcount(deq_valid)). Excess requests are silently clamped. head += P.
- Next count = count + N − P; simultaneous enqueue and pop in the same cycle are both applied.
- Flush: next head = tail = count = 0; enqueue and pop are ignored that cycle. Flush has priority over everything except reset.
- Reset (async assert): head = tail = count = 0; deq_valid = 0; enq_ready = 1; storage is not reset.

## Timing
- Enqueue-to-dequeue latency: 1 cycle. An entry written at edge k appears on deq_* after edge k.
- No combinational path from enq_* to deq_*, and none from deq_pop to enq_ready.
- deq_valid, count and enq_ready are functions of registered state only.
- Full: count = DEPTH gives enq_ready = 0. A pop in that cycle does not re-enable the enqueue until the next cycle.
- Empty: deq_valid = 0. deq_pop is ignored.
- Wrap: writes and reads spanning index DEPTH−1 → 0 continue seamlessly within a single cycle.
- Reset asserted mid-operation clears state immediately. First enqueue is possible on the first edge after rst_n deasserts.

## Configuration
- FETCH_QUEUE_STATS_EN defined adds two outputs:
  - stat_hwm (CW bits): maximum count ever reached since reset or flush.
  - stat_stall (32 bits): saturating count of cycles with enq_valid & !enq_ready & !flush.
  - Both reset to 0. Flush clears stat_hwm only.
- FETCH_QUEUE_STATS_EN undefined: the ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset, then enq mask 2'b11, pcs 0x100/0x104, no taken, deq_pop=0 → next cycle count=2, deq_valid=2'b11, deq_pc 0x100, 0x104.
- Sparse mask 2'b10, pc1=0x208 → stored in the single next entry; deq_valid=2'b01, deq_pc[0]=0x208, count=1.
- Mask 2'b11, enq_taken=2'b01, pcs 0x300/0x304 → only 0x300 enqueued (N=1); deq_taken[0]=1.
- Fill to DEPTH=8 → enq_ready=0. Then enq_valid held with deq_pop=2 → that cycle no enqueue and count 8→6; the next cycle enq_ready=1 (stat_stall=1 when stats enabled).
- Occupancy 3 with head=7, pop 2 and enqueue 2 simultaneously → count=3, head=1, data order preserved across the wrap.
- Count 5 with flush and enqueue in the same cycle → count=0, deq_valid=0, enqueued data discarded; with stats enabled stat_hwm=0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: multi-slot instruction queue between fetch and decode.
//
// Accepts up to ENQ_WIDTH instructions per cycle (pc, data, taken_branch),
// drops slots after the first valid predicted-taken slot, compacts the
// surviving slots into consecutive entries, and presents up to DEQ_WIDTH
// entries in order from the head for decode to pop.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           discard all contents and this cycle's enqueue
//   enq_valid_i       fetch packet present
//   enq_mask_i        per-slot valid (any pattern)
//   enq_pc_i          slot i pc at [i*PC_BITS +: PC_BITS]
//   enq_data_i        slot i instruction word
//   enq_taken_i       slot i predicted taken
//   enq_ready_o       room for a full packet (registered count only)
//   deq_valid_o       thermometer, bit i = head+i valid
//   deq_pc_o          head+i pc
//   deq_data_o        head+i instruction word
//   deq_taken_o       head+i taken flag
//   deq_pop_i         instructions consumed this cycle (clamped)
//   count_o           current occupancy
//
// Optional: define FETCH_QUEUE_STATS_EN to add stat_hwm_o (peak occupancy
// since reset/flush) and stat_stall_o (saturating enqueue-stall cycles).
module fetch_queue #(
  parameter int unsigned PC_BITS    = 32,
  parameter int unsigned INSTR_BITS = 32,
  parameter int unsigned ENQ_WIDTH  = 2,
  parameter int unsigned DEQ_WIDTH  = 2,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEQ_WIDTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            enq_valid_i,
  input  logic [ENQ_WIDTH-1:0]            enq_mask_i,
  input  logic [ENQ_WIDTH*PC_BITS-1:0]    enq_pc_i,
  input  logic [ENQ_WIDTH*INSTR_BITS-1:0] enq_data_i,
  input  logic [ENQ_WIDTH-1:0]            enq_taken_i,
  output logic                            enq_ready_o,
  output logic [DEQ_WIDTH-1:0]            deq_valid_o,
  output logic [DEQ_WIDTH*PC_BITS-1:0]    deq_pc_o,
  output logic [DEQ_WIDTH*INSTR_BITS-1:0] deq_data_o,
  output logic [DEQ_WIDTH-1:0]            deq_taken_o,
  input  logic [PW-1:0]                   deq_pop_i,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [CW-1:0]                   stat_hwm_o,
  output logic [31:0]                     stat_stall_o,
`endif
  output logic [CW-1:0]                   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PC_BITS-1:0]    mem_pc_q   [DEPTH];
  logic [INSTR_BITS-1:0] mem_data_q [DEPTH];
  logic                  mem_tk_q   [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [ENQ_WIDTH-1:0] eff_mask, wr_en;
  logic [AW-1:0]        wr_idx [ENQ_WIDTH];
  logic [CW-1:0]        n_enq, n_pop, n_avail;
  logic                 accept;

  assign enq_ready_o = (count_q <= CW'(DEPTH - ENQ_WIDTH));
  assign accept      = enq_valid_i & enq_ready_o & ~flush_i;
  assign count_o     = count_q;

  // Truncate after the first valid taken slot and assign each survivor the
  // next consecutive entry after tail.
  always_comb begin : p_compact
    logic          kill;
    logic [AW-1:0] off;
    kill     = 1'b0;
    off      = '0;
    n_enq    = '0;
    eff_mask = '0;
    wr_en    = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      eff_mask[i] = enq_mask_i[i] & ~kill;
      if (enq_mask_i[i] & enq_taken_i[i]) kill = 1'b1;
      wr_idx[i] = tail_q + off;
      wr_en[i]  = accept & eff_mask[i];
      if (eff_mask[i]) begin
        off   = off + AW'(1);
        n_enq = n_enq + CW'(1);
      end
    end
  end

  // Pop requests beyond the visible window are clamped.
  always_comb begin
    n_avail = (count_q > CW'(DEQ_WIDTH)) ? CW'(DEQ_WIDTH) : count_q;
    n_pop   = (CW'(deq_pop_i) > n_avail) ? n_avail : CW'(deq_pop_i);
  end

  always_comb begin
    head_d  = head_q + AW'(n_pop);
    tail_d  = accept ? tail_q + AW'(n_enq) : tail_q;
    count_d = count_q + (accept ? n_enq : '0) - n_pop;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (wr_en[i]) begin
        mem_pc_q[wr_idx[i]]   <= enq_pc_i[i*PC_BITS +: PC_BITS];
        mem_data_q[wr_idx[i]] <= enq_data_i[i*INSTR_BITS +: INSTR_BITS];
        mem_tk_q[wr_idx[i]]   <= enq_taken_i[i];
      end
    end
  end

  always_comb begin : p_read
    logic [AW-1:0] rd;
    deq_valid_o = '0;
    deq_pc_o    = '0;
    deq_data_o  = '0;
    deq_taken_o = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      rd                                     = head_q + AW'(i);
      deq_valid_o[i]                         = (count_q > CW'(i));
      deq_pc_o[i*PC_BITS +: PC_BITS]         = mem_pc_q[rd];
      deq_data_o[i*INSTR_BITS +: INSTR_BITS] = mem_data_q[rd];
      deq_taken_o[i]                         = mem_tk_q[rd];
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [CW-1:0] hwm_q, hwm_d;
  logic [31:0]   stall_q, stall_d;

  always_comb begin
    hwm_d   = (count_d > hwm_q) ? count_d : hwm_q;
    stall_d = stall_q;
    if (flush_i) hwm_d = '0;
    if (enq_valid_i && !enq_ready_o && !flush_i && !(&stall_q)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      hwm_q   <= hwm_d;
      stall_q <= stall_d;
    end
  end

  assign stat_hwm_o   = hwm_q;
  assign stat_stall_o = stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue with a queue-based model.
module tb_fetch_queue;
  localparam int unsigned PC_BITS    = 32;
  localparam int unsigned INSTR_BITS = 32;
  localparam int unsigned ENQ_WIDTH  = 2;
  localparam int unsigned DEQ_WIDTH  = 2;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEQ_WIDTH + 1);

  typedef struct packed {
    logic [PC_BITS-1:0]    pc;
    logic [INSTR_BITS-1:0] data;
    logic                  tk;
  } ent_t;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            flush;
  logic                            enq_valid;
  logic [ENQ_WIDTH-1:0]            enq_mask;
  logic [ENQ_WIDTH*PC_BITS-1:0]    enq_pc;
  logic [ENQ_WIDTH*INSTR_BITS-1:0] enq_data;
  logic [ENQ_WIDTH-1:0]            enq_taken;
  logic                            enq_ready;
  logic [DEQ_WIDTH-1:0]            deq_valid;
  logic [DEQ_WIDTH*PC_BITS-1:0]    deq_pc;
  logic [DEQ_WIDTH*INSTR_BITS-1:0] deq_data;
  logic [DEQ_WIDTH-1:0]            deq_taken;
  logic [PW-1:0]                   deq_pop;
  logic [CW-1:0]                   count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [CW-1:0]                   stat_hwm;
  logic [31:0]                     stat_stall;
`endif

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  int   m_hwm   = 0;
  int   m_stall = 0;

  always #5 clk = ~clk;

  fetch_queue #(
    .PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .ENQ_WIDTH(ENQ_WIDTH),
    .DEQ_WIDTH(DEQ_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .enq_valid_i (enq_valid),
    .enq_mask_i  (enq_mask),
    .enq_pc_i    (enq_pc),
    .enq_data_i  (enq_data),
    .enq_taken_i (enq_taken),
    .enq_ready_o (enq_ready),
    .deq_valid_o (deq_valid),
    .deq_pc_o    (deq_pc),
    .deq_data_o  (deq_data),
    .deq_taken_o (deq_taken),
    .deq_pop_i   (deq_pop),
`ifdef FETCH_QUEUE_STATS_EN
    .stat_hwm_o  (stat_hwm),
    .stat_stall_o(stat_stall),
`endif
    .count_o     (count)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every meaningful output against the model queue.
  task automatic check_model();
    chk("count", longint'(count), longint'(q.size()));
    chk("enq_ready", longint'(enq_ready), longint'(q.size() <= int'(DEPTH - ENQ_WIDTH)));
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      chk($sformatf("deq_valid%0d", i), longint'(deq_valid[i]), longint'(q.size() > i));
      if (i < q.size()) begin
        chk($sformatf("deq_pc%0d", i), longint'(deq_pc[i*PC_BITS +: PC_BITS]),
            longint'(q[i].pc));
        chk($sformatf("deq_data%0d", i), longint'(deq_data[i*INSTR_BITS +: INSTR_BITS]),
            longint'(q[i].data));
        chk($sformatf("deq_taken%0d", i), longint'(deq_taken[i]), longint'(q[i].tk));
      end
    end
`ifdef FETCH_QUEUE_STATS_EN
    chk("stat_hwm", longint'(stat_hwm), longint'(m_hwm));
    chk("stat_stall", longint'(stat_stall), longint'(m_stall));
`endif
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_step();
    int  sz;
    int  p;
    bit  rdy;
    sz  = q.size();
    rdy = (sz <= int'(DEPTH - ENQ_WIDTH));
    if (enq_valid && !rdy && !flush && m_stall != -1) m_stall++;
    if (flush) begin
      q.delete();
      m_hwm = 0;
    end else begin
      p = int'(deq_pop);
      if (p > sz) p = sz;
      if (p > int'(DEQ_WIDTH)) p = DEQ_WIDTH;
      for (int k = 0; k < p; k++) void'(q.pop_front());
      if (enq_valid && rdy) begin
        for (int i = 0; i < ENQ_WIDTH; i++) begin
          if (enq_mask[i]) begin
            q.push_back('{pc: enq_pc[i*PC_BITS +: PC_BITS],
                          data: enq_data[i*INSTR_BITS +: INSTR_BITS],
                          tk: enq_taken[i]});
            if (enq_taken[i]) break;
          end
        end
      end
      if (q.size() > m_hwm) m_hwm = q.size();
    end
  endtask

  // Drive one cycle from the falling edge, then check on the next falling edge.
  task automatic cyc(input logic fl, input logic ev, input logic [ENQ_WIDTH-1:0] m,
                     input logic [ENQ_WIDTH-1:0] tk, input logic [PW-1:0] pp,
                     input logic [PC_BITS-1:0] base);
    flush     = fl;
    enq_valid = ev;
    enq_mask  = m;
    enq_taken = tk;
    deq_pop   = pp;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      enq_pc[i*PC_BITS +: PC_BITS]         = base + PC_BITS'(4 * i);
      enq_data[i*INSTR_BITS +: INSTR_BITS] = INSTR_BITS'($urandom);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_mask = '0;
    enq_taken = '0; deq_pop = '0; enq_pc = '0; enq_data = '0;
    @(negedge clk);
    chk("rst_count", longint'(count), 0);
    chk("rst_ready", longint'(enq_ready), 1);
    chk("rst_valid", longint'(deq_valid), 0);
    rst_n = 1'b1;

    // Full two-slot packet.
    cyc(0, 1, 2'b11, 2'b00, 0, 32'h100);
    chk("t1_count", longint'(count), 2);
    chk("t1_valid", longint'(deq_valid), 3);
    chk("t1_pc0", longint'(deq_pc[0 +: PC_BITS]), 32'h100);
    chk("t1_pc1", longint'(deq_pc[PC_BITS +: PC_BITS]), 32'h104);

    // Sparse mask compacts into the next single entry.
    cyc(1, 0, 2'b00, 2'b00, 0, 32'h0);
    cyc(0, 1, 2'b10, 2'b00, 0, 32'h204);
    chk("t2_count", longint'(count), 1);
    chk("t2_valid", longint'(deq_valid), 1);
    chk("t2_pc0", longint'(deq_pc[0 +: PC_BITS]), 32'h208);

    // Slot after a taken branch is dropped.
    cyc(1, 0, 2'b00, 2'b00, 0, 32'h0);
    cyc(0, 1, 2'b11, 2'b01, 0, 32'h300);
    chk("t3_count", longint'(count), 1);
    chk("t3_pc0", longint'(deq_pc[0 +: PC_BITS]), 32'h300);
    chk("t3_tk0", longint'(deq_taken[0]), 1);

    // Fill, then stall with a pop in the same cycle.
    cyc(1, 0, 2'b00, 2'b00, 0, 32'h0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 2'b11, 2'b00, 0, 32'h400 + 32'(8 * k));
    chk("t4_full_count", longint'(count), 8);
    chk("t4_full_ready", longint'(enq_ready), 0);
    cyc(0, 1, 2'b11, 2'b00, 2, 32'h480);
    chk("t4_count", longint'(count), 6);
    chk("t4_ready", longint'(enq_ready), 1);
`ifdef FETCH_QUEUE_STATS_EN
    chk("t4_stall", longint'(stat_stall), 1);
`endif

    // Occupancy 3 starting at index 7, pop and enqueue across the wrap.
    cyc(1, 0, 2'b00, 2'b00, 0, 32'h0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 2'b11, 2'b00, 0, 32'h500 + 32'(8 * k));
    for (int k = 0; k < 3; k++) cyc(0, 0, 2'b00, 2'b00, 2, 32'h0);
    cyc(0, 0, 2'b00, 2'b00, 1, 32'h0);
    cyc(0, 1, 2'b11, 2'b00, 0, 32'h520);
    chk("t5_pre_count", longint'(count), 3);
    chk("t5_pre_pc0", longint'(deq_pc[0 +: PC_BITS]), 32'h51c);
    cyc(0, 1, 2'b11, 2'b00, 2, 32'h528);
    chk("t5_count", longint'(count), 3);
    chk("t5_pc0", longint'(deq_pc[0 +: PC_BITS]), 32'h524);
    chk("t5_pc1", longint'(deq_pc[PC_BITS +: PC_BITS]), 32'h528);

    // Flush wins over a same-cycle enqueue.
    cyc(1, 0, 2'b00, 2'b00, 0, 32'h0);
    cyc(0, 1, 2'b11, 2'b00, 0, 32'h600);
    cyc(0, 1, 2'b11, 2'b00, 0, 32'h608);
    cyc(0, 1, 2'b01, 2'b00, 0, 32'h610);
    chk("t6_pre_count", longint'(count), 5);
    cyc(1, 1, 2'b11, 2'b00, 0, 32'h700);
    chk("t6_count", longint'(count), 0);
    chk("t6_valid", longint'(deq_valid), 0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("t6_hwm", longint'(stat_hwm), 0);
`endif

    // Random traffic, with one asynchronous reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      logic             fl;
      logic             ev;
      logic [ENQ_WIDTH-1:0] m;
      logic [ENQ_WIDTH-1:0] tk;
      logic [PW-1:0]    pp;
      if (n == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", longint'(count), 0);
        chk("mid_rst_valid", longint'(deq_valid), 0);
        chk("mid_rst_ready", longint'(enq_ready), 1);
        q.delete();
        m_hwm   = 0;
        m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      fl = ($urandom_range(0, 63) == 0);
      ev = ($urandom_range(0, 3) != 0);
      m  = ENQ_WIDTH'($urandom);
      tk = '0;
      for (int i = 0; i < ENQ_WIDTH; i++) tk[i] = ($urandom_range(0, 4) == 0);
      // Alternate between pop-heavy and fill-heavy phases.
      if (((n / 100) % 2) == 0) pp = PW'($urandom_range(0, (1 << PW) - 1));
      else pp = ($urandom_range(0, 2) == 0) ? PW'($urandom_range(0, (1 << PW) - 1)) : '0;
      cyc(fl, ev, m, tk, pp, PC_BITS'($urandom) & ~PC_BITS'(3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
